// File: rtl/adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding
// and the bit order of the 1-bit full_adder cell's packed ports.
package adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // full_adder input vector is {cin, b, a}
  localparam int FA_A   = 0;
  localparam int FA_B   = 1;
  localparam int FA_CIN = 2;

  // full_adder output vector is {cout, sum}
  localparam int FA_SUM  = 0;
  localparam int FA_COUT = 1;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
// Ports: in_i {cin,b,a}; out_o {cout,sum}.
module full_adder
  import adder_pkg::*;
(
  input  logic [2:0] in_i,
  output logic [1:0] out_o
);

  logic a;
  logic b;
  logic c;

  assign a = in_i[FA_A];
  assign b = in_i[FA_B];
  assign c = in_i[FA_CIN];

  assign out_o[FA_SUM]  = a ^ b ^ c;
  assign out_o[FA_COUT] = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell, LSB first, WIDTH cycles per op.
// Ports: clk, rst (sync, active high); in_valid/in_ready/in_a/in_b
// [in_sub when SERIAL_ADDER_SUB_EN is defined]; out_valid/out_ready/out_sum/out_carry.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [2:0]       fa_in;
  logic [1:0]       fa_out;
  logic             sub_w;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_w = in_sub;
`else
  assign sub_w = 1'b0;
`endif

  always_comb begin
    fa_in         = '0;
    fa_in[FA_A]   = a_q[0];
    fa_in[FA_B]   = b_q[0];
    fa_in[FA_CIN] = carry_q;
  end

  full_adder u_fa (
    .in_i  (fa_in),
    .out_o (fa_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Subtract is A + ~B + 1: invert B, seed carry with 1
          a_d     = in_a;
          b_d     = sub_w ? ~in_b : in_b;
          carry_d = sub_w;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {fa_out[FA_SUM], sum_q[WIDTH-1:1]};
        carry_d = fa_out[FA_COUT];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_sum   = out_valid ? sum_q : '0;
  assign out_carry = out_valid & carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed literal cases plus
// randomized traffic compared against a transaction-level model.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_carry;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
`ifdef SERIAL_ADDER_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: 0 idle, 1 busy, 2 result waiting
  int           m_mode = 0;
  int           m_left = 0;
  logic [W-1:0] m_sum;
  logic         m_carry;
  bit           m_rst_seen = 0;
  bit           m_after_rst = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode      = 0;
      m_rst_seen  = 1;
      m_after_rst = 1;
    end else begin
      m_after_rst = 0;
      case (m_mode)
        0: if (in_valid) begin
          int unsigned a;
          int unsigned b;
          bit          s;
          a = int'(in_a);
          b = int'(in_b);
          s = 0;
`ifdef SERIAL_ADDER_SUB_EN
          s = in_sub;
`endif
          if (s) begin
            m_sum   = W'(a - b);
            m_carry = (a >= b);
          end else begin
            m_sum   = W'(a + b);
            m_carry = ((a + b) >> W) != 0;
          end
          m_left = W;
          m_mode = 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) m_mode = 2;
        end
        default: if (out_ready) m_mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_rst_seen && !rst) begin
      chk("m_in_ready", 32'(in_ready), 32'(m_mode == 0));
      chk("m_out_valid", 32'(out_valid), 32'(m_mode == 2));
      if (m_mode == 2) begin
        chk("m_sum", 32'(out_sum), 32'(m_sum));
        chk("m_carry", 32'(out_carry), 32'(m_carry));
      end
      if (m_after_rst) begin
        chk("rst_sum", 32'(out_sum), 32'd0);
        chk("rst_carry", 32'(out_carry), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for out_valid; returns edges elapsed since the caller's last edge.
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    if (!out_valid) chk("timeout_valid", 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] es,
                        input logic ec, input int hold);
    int n;
    logic [W-1:0] snap;
    in_a      = a;
    in_b      = b;
    in_sub    = s;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    tick();
    in_valid = 1'b0;
    wait_valid(n);
    chk("latency", 32'(n), 32'(W));
    chk("sum", 32'(out_sum), 32'(es));
    chk("carry", 32'(out_carry), 32'(ec));
    snap = out_sum;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_sum", 32'(out_sum), 32'(snap));
      chk("bp_carry", 32'(out_carry), 32'(ec));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("post_valid", 32'(out_valid), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_sum", 32'(out_sum), 32'd0);
    chk("reset_carry", 32'(out_carry), 32'd0);
    rst = 1'b0;
    tick();

    run_op(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
    run_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0);
    run_op(8'hC3, 8'h7E, 1'b0, 8'h41, 1'b1, 5);

    // Abort mid-run when the bit counter reads 3
    in_a     = 8'hAA;
    in_b     = 8'h55;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_sum", 32'(out_sum), 32'd0);
    chk("abort_carry", 32'(out_carry), 32'd0);
    run_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 0);

    // Back-to-back with in_valid held high
    out_ready = 1'b1;
    in_a      = 8'hFF;
    in_b      = 8'h01;
    in_valid  = 1'b1;
    tick();
    in_a = 8'h01;
    in_b = 8'h01;
    wait_valid(n);
    chk("b2b1_latency", 32'(n), 32'(W));
    chk("b2b1_sum", 32'(out_sum), 32'h00);
    chk("b2b1_carry", 32'(out_carry), 32'd1);
    tick();
    chk("b2b_idle", 32'(in_ready), 32'd1);
    tick();
    chk("b2b_accept", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    wait_valid(n);
    chk("b2b2_latency", 32'(n), 32'(W));
    chk("b2b2_sum", 32'(out_sum), 32'h02);
    chk("b2b2_carry", 32'(out_carry), 32'd0);
    tick();

`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'd10, 8'd3, 1'b1, 8'h07, 1'b1, 0);
    run_op(8'd3, 8'd10, 1'b1, 8'hF9, 1'b0, 2);
    run_op(8'd42, 8'd42, 1'b1, 8'h00, 1'b1, 0);
`endif

    // Random traffic; the model process does all checking here
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      in_sub    = $urandom_range(1);
      out_ready = ($urandom_range(2) != 0);
      rst       = ($urandom_range(199) == 0);
      tick();
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
